signed_sat_accum: RTL and testbench
===================================

# signed_sat_accum

Streaming signed accumulator with saturation, parametrised in data width. Sums a frame of signed beats (terminated by `up_last`) into a W-bit accumulator that clamps to the most positive or most negative value on overflow instead of wrapping. It returns one result per frame, with a per-frame saturation flag. It is the sequential, handshaked successor to the 4-bit combinational saturating adder and sits between sample producers and any downstream stage that needs bounded frame sums.

## Interface
- `W`, 8: data and accumulator width, two's complement; legal range 2..32.
- `CNT_W`, 4: width of the per-frame saturation event counter.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst_n` in 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `up_valid` in 1: input beat valid.
- `up_ready` out 1: block can accept a beat.
- `up_data` in W: signed input beat.
- `up_last` in 1: beat is the final beat of its frame.
- `down_valid` out 1: frame result valid.
- `down_ready` in 1: consumer accepts the result.
- `down_data` out W: signed saturated frame sum.
- `down_sat` out 1: at least one beat of the frame saturated.
- `down_sat_cnt` out CNT_W: number of saturating beats in the frame. Present only with `SIGNED_SAT_ACCUM_CNT_EN`; see Configuration.

## Operation
- Beat accepted when `up_valid && up_ready`.
- `up_ready = rst_n && (!down_valid || down_ready)`.
  - Accumulation of the next frame overlaps with holding the previous result.
  - Accumulation stalls only while the result is held and not being consumed.
- Saturating add: `s = acc + up_data` mod 2^W.
  - Overflow iff `acc[W-1] == up_data[W-1]` and `s[W-1] != acc[W-1]`.
  - On positive overflow, result = 2^(W-1)-1; on negative overflow, result = -2^(W-1); otherwise result = `s`.
- Clamping is not sticky: later beats add to the clamped value and can move it back into range.
- Per accepted beat, not last:
  - `acc <= sat_add(acc, up_data)`.
  - Frame saturation flag `fsat <= fsat | ovf`.
  - Counter `fcnt` increments on `ovf`. The counter saturates at 2^CNT_W-1 and does not wrap.
- Accepted beat with `up_last`:
  - `down_data <= sat_add(acc, up_data)`.
  - `down_sat <= fsat | ovf`.
  - `down_sat_cnt` takes `fcnt` plus this beat's `ovf`, with the same saturation rule.
  - `down_valid <= 1`.
  - `acc`, `fsat` and `fcnt` clear to 0 in the same cycle.
- A single-beat frame yields `down_data = up_data` and `down_sat = 0`.
- `down_valid` clears on `down_ready` unless a new last beat is accepted in the same cycle. In that case the new result loads and `down_valid` stays 1. This gives back-to-back results with no bubble.
- `down_data`, `down_sat` and `down_sat_cnt` stay stable while `down_valid && !down_ready`.
- `up_data` and `up_last` are ignored when `!up_valid`.

## Timing
- Latency: a result is visible 1 cycle after its last beat is accepted, i.e. registered output.
- Throughput: 1 beat per cycle, including single-beat frames, with `down_ready` held at 1.
- Reset, while `rst_n` is low on an edge:
  - `acc`, `fsat` and `fcnt` clear to 0.
  - `down_valid`, `down_data`, `down_sat` and `down_sat_cnt` clear to 0.
  - `up_ready` is 0.
- Reset mid-frame discards the partial frame and any held result with no output. The first beat after reset starts a new frame.
- No combinational path from `up_valid` or `up_data` to any output. `up_ready` depends combinationally only on `down_valid`, `down_ready` and `rst_n`.

## Configuration
- `SIGNED_SAT_ACCUM_CNT_EN` defined:
  - `fcnt` and the `down_sat_cnt` register are built.
  - `down_sat_cnt` reports the saturating-beat count as specified under Operation.
- Not defined:
  - No counter logic is built.
  - The `down_sat_cnt` port remains and is tied to 0.
  - `down_sat` behaviour is unchanged.

## Test plan
- W=8, `down_ready`=1: frame 10, 20, -5 (last) → `down_data`=25, `down_sat`=0, `down_sat_cnt`=0, one cycle after the last beat.
- W=8: frame 100, 100 (last) → `down_data`=127, `down_sat`=1, `down_sat_cnt`=1. Then frame -100, -100 (last) → `down_data`=-128, `down_sat`=1.
- W=8, non-sticky clamp: frame 100, 100, -50 (last) → `down_data`=77, `down_sat`=1, `down_sat_cnt`=1.
- Backpressure with single-beat frames 5, 6, 7 (each last):
  - Hold `down_ready`=0 while result 5 is valid → `up_ready`=0, `down_data` stays 5.
  - Then set `down_ready`=1 → results 6 and 7 follow on consecutive cycles.
- W=4, CNT_W=2, macro defined: frame of five beats of 7 (last on the fifth) → `down_data`=7, `down_sat`=1, `down_sat_cnt`=3 (counter saturated). Same frame without the macro → `down_sat_cnt`=0.
- Reset mid-frame:
  - Accept 50, 50, then pull `rst_n` low for 1 cycle → all outputs 0.
  - Then frame 1 (last) → `down_data`=1, `down_sat`=0.

Source files
------------

// File: rtl/signed_sat_accum.sv
// signed_sat_accum: streaming frame accumulator that clamps instead of
// wrapping, one registered result per frame with a saturation flag.
// Ports: clk, rst_n (sync, active low); up_valid/up_ready/up_data/up_last
// beat input; down_valid/down_ready/down_data/down_sat/down_sat_cnt result.
// Macro SIGNED_SAT_ACCUM_CNT_EN builds the saturating-beat counter;
// without it down_sat_cnt is tied to 0.
module signed_sat_accum #(
  parameter int W     = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [W-1:0]     up_data,
  input  logic             up_last,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [W-1:0]     down_data,
  output logic             down_sat,
  output logic [CNT_W-1:0] down_sat_cnt
);

  localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  logic [W-1:0] acc;
  logic [W-1:0] sum;
  logic [W-1:0] sat;
  logic         fsat;
  logic         ovf;
  logic         take;

  // Next frame may fill while the previous result is held.
  assign up_ready = rst_n && (!down_valid || down_ready);
  assign take     = up_valid && up_ready;

  assign sum = acc + up_data;
  assign ovf = (acc[W-1] == up_data[W-1]) &&
               (sum[W-1] != acc[W-1]);

  always_comb begin
    sat = sum;
    if (ovf) begin
      sat = acc[W-1] ? MINV : MAXV;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc        <= '0;
      fsat       <= 1'b0;
      down_valid <= 1'b0;
      down_data  <= '0;
      down_sat   <= 1'b0;
    end else begin
      // A last beat in the same cycle overrides this clear.
      if (down_ready) begin
        down_valid <= 1'b0;
      end
      if (take) begin
        if (up_last) begin
          down_data  <= sat;
          down_sat   <= fsat | ovf;
          down_valid <= 1'b1;
          acc        <= '0;
          fsat       <= 1'b0;
        end else begin
          acc  <= sat;
          fsat <= fsat | ovf;
        end
      end
    end
  end

`ifdef SIGNED_SAT_ACCUM_CNT_EN
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [CNT_W-1:0] fcnt;
  logic [CNT_W-1:0] cnt_nx;

  // Counter sticks at all-ones rather than wrapping.
  assign cnt_nx = (ovf && fcnt != CMAX) ?
                  fcnt + CNT_W'(1) : fcnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fcnt         <= '0;
      down_sat_cnt <= '0;
    end else if (take) begin
      if (up_last) begin
        down_sat_cnt <= cnt_nx;
        fcnt         <= '0;
      end else begin
        fcnt <= cnt_nx;
      end
    end
  end
`else
  assign down_sat_cnt = '0;
`endif

endmodule

// File: tb/tb_signed_sat_accum.sv
// tb_signed_sat_accum: directed bench with an integer-level frame model
// for the W=8 instance and literal checks for a W=4, CNT_W=2 instance.
module tb_signed_sat_accum;

`ifdef SIGNED_SAT_ACCUM_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       up_valid;
  logic       up_ready;
  logic [7:0] up_data;
  logic       up_last;
  logic       down_valid;
  logic       down_ready;
  logic [7:0] down_data;
  logic       down_sat;
  logic [3:0] down_sat_cnt;

  logic       b_valid;
  logic       b_ready;
  logic [3:0] b_data;
  logic       b_last;
  logic       b_dvalid;
  logic       b_dready;
  logic [3:0] b_ddata;
  logic       b_dsat;
  logic [1:0] b_dcnt;

  int checks;
  int failures;

  signed_sat_accum #(.W(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .up_valid(up_valid), .up_ready(up_ready),
    .up_data(up_data), .up_last(up_last),
    .down_valid(down_valid), .down_ready(down_ready),
    .down_data(down_data), .down_sat(down_sat),
    .down_sat_cnt(down_sat_cnt)
  );

  signed_sat_accum #(.W(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .up_valid(b_valid), .up_ready(b_ready),
    .up_data(b_data), .up_last(b_last),
    .down_valid(b_dvalid), .down_ready(b_dready),
    .down_data(b_ddata), .down_sat(b_dsat),
    .down_sat_cnt(b_dcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string n, int a, int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endfunction

  typedef struct {
    int d;
    int s;
    int c;
  } res_t;

  res_t q[$];
  int   m_sum;
  int   m_sat;
  int   m_cnt;

  // Model: exact integer sum clamped to [-128,127] after every beat;
  // at most one result waits in q for the consumer.
  always @(negedge clk) begin
    int   t;
    int   ov;
    int   er;
    res_t r;
    er = (rst_n && (q.size() == 0 || down_ready)) ? 1 : 0;
    chk("m_up_ready", int'(up_ready), er);
    chk("m_down_valid", int'(down_valid), (q.size() > 0) ? 1 : 0);
    if (q.size() > 0) begin
      chk("m_down_data", int'($signed(down_data)), q[0].d);
      chk("m_down_sat", int'(down_sat), q[0].s);
      chk("m_down_sat_cnt", int'(down_sat_cnt), q[0].c);
    end
    if (!rst_n) begin
      q.delete();
      m_sum = 0;
      m_sat = 0;
      m_cnt = 0;
    end else begin
      if (q.size() > 0 && down_ready) void'(q.pop_front());
      if (up_valid && er == 1) begin
        t  = m_sum + int'($signed(up_data));
        ov = 0;
        if (t > 127) begin
          t  = 127;
          ov = 1;
        end else if (t < -128) begin
          t  = -128;
          ov = 1;
        end
        if (ov == 1) begin
          m_sat = 1;
          if (m_cnt < 15) m_cnt++;
        end
        if (up_last) begin
          r.d = t;
          r.s = m_sat;
          r.c = CNT_ON ? m_cnt : 0;
          q.push_back(r);
          m_sum = 0;
          m_sat = 0;
          m_cnt = 0;
        end else begin
          m_sum = t;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge
  // that accepted the beat.
  task automatic beat(input int d, input bit last);
    int n;
    up_valid = 1'b1;
    up_data  = 8'(d);
    up_last  = last;
    n = 0;
    @(negedge clk);
    while (!up_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) chk("beat_timeout", 1, 0);
    step();
    up_valid = 1'b0;
    up_last  = 1'b0;
  endtask

  task automatic res(string n, int d, int s, int c);
    @(negedge clk);
    chk({n, "_valid"}, int'(down_valid), 1);
    chk({n, "_data"}, int'($signed(down_data)), d);
    chk({n, "_sat"}, int'(down_sat), s);
    chk({n, "_cnt"}, int'(down_sat_cnt), c);
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_sum    = 0;
    m_sat    = 0;
    m_cnt    = 0;
    rst_n      = 1'b0;
    up_valid   = 1'b0;
    up_data    = '0;
    up_last    = 1'b0;
    down_ready = 1'b1;
    b_valid    = 1'b0;
    b_data     = '0;
    b_last     = 1'b0;
    b_dready   = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_up_ready", int'(up_ready), 0);
    chk("rst_down_valid", int'(down_valid), 0);
    chk("rst_down_data", int'(down_data), 0);
    chk("rst_down_sat", int'(down_sat), 0);
    chk("rst_down_cnt", int'(down_sat_cnt), 0);
    chk("rst_b_valid", int'(b_dvalid), 0);
    step();
    rst_n = 1'b1;

    beat(10, 0);
    beat(20, 0);
    beat(-5, 1);
    res("sum25", 25, 0, 0);

    beat(100, 0);
    beat(100, 1);
    res("pos_sat", 127, 1, CNT_ON ? 1 : 0);
    beat(-100, 0);
    beat(-100, 1);
    res("neg_sat", -128, 1, CNT_ON ? 1 : 0);

    beat(100, 0);
    beat(100, 0);
    beat(-50, 1);
    res("nonsticky", 77, 1, CNT_ON ? 1 : 0);

    down_ready = 1'b0;
    beat(5, 1);
    up_valid = 1'b1;
    up_data  = 8'd6;
    up_last  = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("bp_up_ready", int'(up_ready), 0);
      chk("bp_hold_data", int'(down_data), 5);
      chk("bp_hold_valid", int'(down_valid), 1);
    end
    step();
    down_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", int'(up_ready), 1);
    step();
    up_data = 8'd7;
    @(negedge clk);
    chk("b2b_6", int'(down_data), 6);
    chk("b2b_6_valid", int'(down_valid), 1);
    step();
    up_valid = 1'b0;
    up_last  = 1'b0;
    @(negedge clk);
    chk("b2b_7", int'(down_data), 7);
    chk("b2b_7_valid", int'(down_valid), 1);
    step();

    beat(50, 0);
    beat(50, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", int'(down_valid), 0);
    chk("mid_rst_data", int'(down_data), 0);
    chk("mid_rst_sat", int'(down_sat), 0);
    chk("mid_rst_cnt", int'(down_sat_cnt), 0);
    step();
    beat(1, 1);
    res("after_rst", 1, 0, 0);

    b_valid = 1'b1;
    b_data  = 4'd7;
    b_last  = 1'b0;
    @(negedge clk);
    chk("w4_up_ready", int'(b_ready), 1);
    repeat (4) step();
    b_last = 1'b1;
    step();
    b_valid = 1'b0;
    b_last  = 1'b0;
    @(negedge clk);
    chk("w4_valid", int'(b_dvalid), 1);
    chk("w4_data", int'($signed(b_ddata)), 7);
    chk("w4_sat", int'(b_dsat), 1);
    chk("w4_cnt", int'(b_dcnt), CNT_ON ? 3 : 0);
    step();
    @(negedge clk);
    chk("w4_consumed", int'(b_dvalid), 0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
